line_matrix_programmer: RTL and testbench

LINE_MATRIX_PROGRAMMER -- requirements
Module: line_matrix_programmer

---
 rtl/line_matrix_programmer.sv | 185 ++++++++++++++++++
 tb/tb_line_matrix_programmer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/line_matrix_programmer.sv
// Line-matrix programmer: sequences route programming (select setup, one lm_clk
// pulse, hold) and matrix clears (lm_rstn pulse, settle) behind a valid/ready port.
//
// state    | meaning
// INIT_RST | post-reset matrix reset, lm_rstn low, no done on exit
// IDLE     | waiting for a command, cmd_ready high
// SETUP    | selects stable, lm_clk low
// CLK_HI   | lm_clk high, matrix captures the route
// HOLD     | lm_clk low, selects held
// CLR_RST  | clear command, lm_rstn low
// SETTLE   | lm_rstn high, matrix recovers from reset
module line_matrix_programmer #(
  parameter int SEL_W        = 4,
  parameter int HALF_PERIOD  = 4,
  parameter int RESET_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_clear,
  input  logic [SEL_W-1:0] cmd_in_sel,
  input  logic [SEL_W-1:0] cmd_out_sel,
  output logic             busy,
  output logic             done,
  output logic [7:0]       route_count,
  output logic             lm_clk,
  output logic             lm_rstn,
  output logic [SEL_W-1:0] lm_input_select,
  output logic [SEL_W-1:0] lm_output_select
);

  typedef enum logic [2:0] {
    INIT_RST,
    IDLE,
    SETUP,
    CLK_HI,
    HOLD,
    CLR_RST,
    SETTLE
  } state_t;

  localparam logic [7:0] HP_CNT  = 8'(HALF_PERIOD);
  localparam logic [7:0] RST_CNT = 8'(RESET_CYCLES);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic             r_clr;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_route_count;
  logic             r_lm_clk;
  logic             r_lm_rstn;
  logic [SEL_W-1:0] r_in_sel;
  logic [SEL_W-1:0] r_out_sel;

  state_t           w_state_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_clr_nxt;
  logic             w_done_nxt;
  logic [7:0]       w_count_nxt;
  logic [SEL_W-1:0] w_in_nxt;
  logic [SEL_W-1:0] w_out_nxt;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_cnt <= 8'd1);
  assign w_accept = cmd_valid && r_cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= INIT_RST;
      r_cnt         <= RST_CNT;
      r_clr         <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_route_count <= 8'd0;
      r_lm_clk      <= 1'b0;
      r_lm_rstn     <= 1'b0;
      r_in_sel      <= '0;
      r_out_sel     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_clr         <= w_clr_nxt;
      r_cmd_ready   <= (w_state_nxt == IDLE);
      r_busy        <= (w_state_nxt != IDLE);
      r_done        <= w_done_nxt;
      r_route_count <= w_count_nxt;
      r_lm_clk      <= (w_state_nxt == CLK_HI);
      r_lm_rstn     <= !((w_state_nxt == INIT_RST) || (w_state_nxt == CLR_RST));
      r_in_sel      <= w_in_nxt;
      r_out_sel     <= w_out_nxt;
    end
  end

  // Each state is entered with its full duration loaded and leaves on count 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - 8'd1;
    w_clr_nxt   = r_clr;
    w_done_nxt  = 1'b0;
    w_count_nxt = r_route_count;
    w_in_nxt    = r_in_sel;
    w_out_nxt   = r_out_sel;
    case (r_state)
      INIT_RST: begin
        if (w_last) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = HP_CNT;
          w_clr_nxt   = 1'b0;
        end
      end
      IDLE: begin
        w_cnt_nxt = 8'd0;
        if (w_accept) begin
          if (cmd_clear) begin
            w_state_nxt = CLR_RST;
            w_cnt_nxt   = RST_CNT;
            w_clr_nxt   = 1'b1;
          end else begin
            w_state_nxt = SETUP;
            w_cnt_nxt   = HP_CNT;
            w_in_nxt    = cmd_in_sel;
            w_out_nxt   = cmd_out_sel;
          end
        end
      end
      SETUP: begin
        if (w_last) begin
          w_state_nxt = CLK_HI;
          w_cnt_nxt   = HP_CNT;
        end
      end
      CLK_HI: begin
        if (w_last) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = HP_CNT;
        end
      end
      HOLD: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
          w_done_nxt  = 1'b1;
          w_count_nxt = (r_route_count == 8'hFF) ? 8'hFF : r_route_count + 8'd1;
        end
      end
      CLR_RST: begin
        if (w_last) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = HP_CNT;
        end
      end
      SETTLE: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
          // Only a clear command reports completion; the power-up pass is silent.
          if (r_clr) begin
            w_done_nxt  = 1'b1;
            w_count_nxt = 8'd0;
            w_clr_nxt   = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = INIT_RST;
        w_cnt_nxt   = RST_CNT;
      end
    endcase
  end

  assign cmd_ready        = r_cmd_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign route_count      = r_route_count;
  assign lm_clk           = r_lm_clk;
  assign lm_rstn          = r_lm_rstn;
  assign lm_input_select  = r_in_sel;
  assign lm_output_select = r_out_sel;

endmodule

// File: tb/tb_line_matrix_programmer.sv
// Bench for line_matrix_programmer: directed commands push expected completions
// into a scoreboard; a monitor pops and checks them on every done pulse.
module tb_line_matrix_programmer;

  localparam int HP  = 2;
  localparam int RC  = 3;
  localparam int LAT_ROUTE = 3 * HP + 1;
  localparam int LAT_CLEAR = RC + HP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_clear = 1'b0;
  logic [3:0] cmd_in_sel = 4'd0;
  logic [3:0] cmd_out_sel = 4'd0;
  logic       cmd_ready, busy, done, lm_clk, lm_rstn;
  logic [7:0] route_count;
  logic [3:0] lm_input_select, lm_output_select;

  line_matrix_programmer #(.SEL_W(4), .HALF_PERIOD(HP), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_in_sel(cmd_in_sel), .cmd_out_sel(cmd_out_sel),
    .busy(busy), .done(done), .route_count(route_count), .lm_clk(lm_clk),
    .lm_rstn(lm_rstn), .lm_input_select(lm_input_select),
    .lm_output_select(lm_output_select)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   due;
    int   cnt;
    logic clr;
    int   isel;
    int   osel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_assert = 0;
  int n_fail = 0;
  int model_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.due);
        chk("done_route_count", int'(route_count), mon_e.cnt);
        chk("done_cmd_ready", int'(cmd_ready), 1);
        if (!mon_e.clr) begin
          chk("done_in_sel", int'(lm_input_select), mon_e.isel);
          chk("done_out_sel", int'(lm_output_select), mon_e.osel);
        end
      end
    end
  end

  // Called at a negedge. Returns at the negedge of cycle 1; base is the cyc
  // value that cycle 0 (the acceptance cycle) would carry.
  task automatic send(input logic clr, input int isel, input int osel, output int base);
    exp_t e;
    int n;
    cmd_valid   = 1'b1;
    cmd_clear   = clr;
    cmd_in_sel  = 4'(isel);
    cmd_out_sel = 4'(osel);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    base = cyc;
    if (n >= 100) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      base = cyc - 1;
      model_cnt = clr ? 0 : ((model_cnt == 255) ? 255 : model_cnt + 1);
      e.due  = base + (clr ? LAT_CLEAR : LAT_ROUTE);
      e.cnt  = model_cnt;
      e.clr  = clr;
      e.isel = isel;
      e.osel = osel;
      sb.push_back(e);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int b0, b1, b2, bc, n;

    // Reset state and power-up sequence.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_lm_clk", int'(lm_clk), 0);
    chk("rst_lm_rstn", int'(lm_rstn), 0);
    chk("rst_in_sel", int'(lm_input_select), 0);
    chk("rst_out_sel", int'(lm_output_select), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_route_count", int'(route_count), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("pwr_lm_rstn", int'(lm_rstn), (k < RC) ? 0 : 1);
      chk("pwr_cmd_ready", int'(cmd_ready), (k == RC + HP) ? 1 : 0);
      if (k < 5) @(negedge clk);
    end

    // Single route 5/9.
    send(1'b0, 5, 9, b0);
    for (int k = 1; k <= LAT_ROUTE; k++) begin
      chk("route_lm_clk", int'(lm_clk), (k == 3 || k == 4) ? 1 : 0);
      chk("route_in_sel", int'(lm_input_select), 5);
      chk("route_out_sel", int'(lm_output_select), 9);
      chk("route_busy", int'(busy), (k < LAT_ROUTE) ? 1 : 0);
      if (k < LAT_ROUTE) @(negedge clk);
    end

    // Back-to-back routes 1/2 then 3/4 with cmd_valid held.
    send(1'b0, 1, 2, b1);
    fork
      send(1'b0, 3, 4, b2);
      begin
        for (int k = 1; k <= 14; k++) begin
          chk("b2b_in_sel", int'(lm_input_select), (k <= 7) ? 1 : 3);
          chk("b2b_out_sel", int'(lm_output_select), (k <= 7) ? 2 : 4);
          chk("b2b_lm_clk", int'(lm_clk), (k == 3 || k == 4 || k == 10 || k == 11) ? 1 : 0);
          if (k < 14) @(negedge clk);
        end
      end
    join
    chk("b2b_accept_gap", b2 - b1, 7);

    // Clear after three routes; selects presented with it are ignored.
    send(1'b1, 15, 15, bc);
    for (int k = 1; k <= LAT_CLEAR; k++) begin
      chk("clr_lm_rstn", int'(lm_rstn), (k <= RC) ? 0 : 1);
      chk("clr_lm_clk", int'(lm_clk), 0);
      chk("clr_in_sel", int'(lm_input_select), 3);
      chk("clr_out_sel", int'(lm_output_select), 4);
      if (k < LAT_CLEAR) @(negedge clk);
    end

    // Saturation of route_count.
    for (int i = 0; i < 256; i++) send(1'b0, i % 16, (i + 7) % 16, b0);
    drain(20);
    chk("sat_route_count", int'(route_count), 255);

    // Abort during CLK_HI.
    send(1'b0, 6, 7, b0);
    n = 0;
    while (!lm_clk && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_clk_hi", int'(lm_clk), 1);
    rst = 1'b1;
    void'(sb.pop_back());
    model_cnt = 0;
    @(negedge clk);
    chk("abort_lm_clk", int'(lm_clk), 0);
    chk("abort_lm_rstn", int'(lm_rstn), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_cmd_ready", int'(cmd_ready), 0);
    chk("abort_route_count", int'(route_count), 0);
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_recover_ready", int'(cmd_ready), 1);
    repeat (10) @(negedge clk);

    // One route after the abort counts from zero.
    send(1'b0, 2, 3, b0);
    drain(20);
    chk("post_abort_count", int'(route_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
